game_ctrl: RTL and testbench

Game-level sequencer for the score datapath. Runs a synchronous IDLE/RUN/OVER state machine from the player button, the collision flag and the end-of-frame pulse. It produces the game_start/game_over pulses and the prescaled score tick consumed by the score counter, plus the per-frame RNG step. It also keeps a high-score register by comparing the final BCD score at game over.

---
 rtl/game_ctrl.sv | 133 +++++++++++++
 tb/tb_game_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
// Game-level sequencer: IDLE/RUN/OVER FSM, score tick prescaler, per-frame RNG step,
// restart dwell timer and a BCD high-score register.
module game_ctrl #(
  parameter int unsigned TICK_DIV    = 1,
  parameter int unsigned OVER_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_btn,
  input  logic        collision,
  input  logic        frame_end,
  input  logic [15:0] score_in,
  output logic        game_start,
  output logic        game_over,
  output logic        score_tick,
  output logic        rng_step,
  output logic [1:0]  game_state,
  output logic [15:0] high_score,
  output logic        new_high
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_OVER = 2'b10;

  localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);
  localparam logic [7:0] OVER_LIM  = 8'(OVER_FRAMES);

  logic [1:0]  state_q, state_d;
  logic [7:0]  presc_q, presc_d;
  logic [7:0]  dwell_q, dwell_d;
  logic        btn_q, btn_d;
  logic        start_q, start_d;
  logic        over_q, over_d;
  logic        tick_q, tick_d;
  logic        rng_q, rng_d;
  logic [15:0] hs_q, hs_d;
  logic        nh_q, nh_d;
  logic        start_edge;

  assign start_edge = start_btn & ~btn_q;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    dwell_d = dwell_q;
    btn_d   = start_btn;
    start_d = 1'b0;
    over_d  = 1'b0;
    tick_d  = 1'b0;
    rng_d   = 1'b0;
    hs_d    = hs_q;
    nh_d    = nh_q;

    // Final score is judged in the cycle game_over is visible, i.e. the first OVER cycle.
    if (over_q && (score_in > hs_q)) begin
      hs_d = score_in;
      nh_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d = S_RUN;
          start_d = 1'b1;
          presc_d = 8'd0;
          nh_d    = 1'b0;
        end
      end
      S_RUN: begin
        if (collision) begin
          state_d = S_OVER;
          over_d  = 1'b1;
          dwell_d = 8'd0;
        end else if (frame_end) begin
          rng_d = 1'b1;
          if (presc_q == TICK_LAST) begin
            presc_d = 8'd0;
            tick_d  = 1'b1;
          end else begin
            presc_d = presc_q + 8'd1;
          end
        end
      end
      S_OVER: begin
        if (frame_end && (dwell_q != OVER_LIM)) dwell_d = dwell_q + 8'd1;
        // An early press is simply dropped; the edge detector already consumed it.
        if (start_edge && (dwell_q == OVER_LIM)) begin
          state_d = S_RUN;
          start_d = 1'b1;
          presc_d = 8'd0;
          nh_d    = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      presc_q <= 8'd0;
      dwell_q <= 8'd0;
      btn_q   <= 1'b0;
      start_q <= 1'b0;
      over_q  <= 1'b0;
      tick_q  <= 1'b0;
      rng_q   <= 1'b0;
      hs_q    <= 16'h0000;
      nh_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      dwell_q <= dwell_d;
      btn_q   <= btn_d;
      start_q <= start_d;
      over_q  <= over_d;
      tick_q  <= tick_d;
      rng_q   <= rng_d;
      hs_q    <= hs_d;
      nh_q    <= nh_d;
    end
  end

  assign game_start = start_q;
  assign game_over  = over_q;
  assign score_tick = tick_q;
  assign rng_step   = rng_q;
  assign game_state = (state_q == 2'b11) ? S_IDLE : state_q;
  assign high_score = hs_q;
  assign new_high   = nh_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed + randomized bench for game_ctrl against a frame-counting reference model.
module tb_game_ctrl;
  localparam int TD = 4;
  localparam int OF = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_btn = 1'b0, collision = 1'b0, frame_end = 1'b0;
  logic [15:0] score_in = 16'h0;
  logic        game_start, game_over, score_tick, rng_step, new_high;
  logic [1:0]  game_state;
  logic [15:0] high_score;

  int checks = 0;
  int errors = 0;

  // reference model: mode 0 idle, 1 running, 2 over
  int  m_mode, m_run_frames, m_over_frames, m_hs;
  bit  m_nh, m_prev;
  bit  e_start, e_over, e_tick, e_rng;

  game_ctrl #(.TICK_DIV(TD), .OVER_FRAMES(OF)) dut (
    .clk(clk), .rst_n(rst_n), .start_btn(start_btn), .collision(collision),
    .frame_end(frame_end), .score_in(score_in), .game_start(game_start),
    .game_over(game_over), .score_tick(score_tick), .rng_step(rng_step),
    .game_state(game_state), .high_score(high_score), .new_high(new_high)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("game_start", 16'(game_start), 16'(e_start));
    chk("game_over",  16'(game_over),  16'(e_over));
    chk("score_tick", 16'(score_tick), 16'(e_tick));
    chk("rng_step",   16'(rng_step),   16'(e_rng));
    chk("game_state", 16'(game_state), 16'(m_mode));
    chk("high_score", high_score,      16'(m_hs));
    chk("new_high",   16'(new_high),   16'(m_nh));
  endtask

  task automatic model_reset();
    m_mode = 0; m_run_frames = 0; m_over_frames = 0; m_hs = 0;
    m_nh = 0; m_prev = 0;
    e_start = 0; e_over = 0; e_tick = 0; e_rng = 0;
  endtask

  task automatic model_clock(input bit btn, input bit col, input bit fe, input int score);
    bit edge_seen;
    edge_seen = btn && !m_prev;
    if (e_over && score > m_hs) begin
      m_hs = score;
      m_nh = 1;
    end
    e_start = 0; e_over = 0; e_tick = 0; e_rng = 0;
    if (m_mode == 0) begin
      if (edge_seen) begin m_mode = 1; e_start = 1; m_run_frames = 0; m_nh = 0; end
    end else if (m_mode == 1) begin
      if (col) begin
        m_mode = 2; e_over = 1; m_over_frames = 0;
      end else if (fe) begin
        m_run_frames++;
        e_rng  = 1;
        e_tick = (m_run_frames % TD) == 0;
      end
    end else begin
      if (edge_seen && m_over_frames == OF) begin
        m_mode = 1; e_start = 1; m_run_frames = 0; m_nh = 0;
      end else if (fe && m_over_frames < OF) begin
        m_over_frames++;
      end
    end
    m_prev = btn;
  endtask

  task automatic step(input bit btn, input bit col, input bit fe, input logic [15:0] score);
    start_btn = btn; collision = col; frame_end = fe; score_in = score;
    @(posedge clk);
    model_clock(btn, col, fe, int'(score));
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    start_btn = 0; collision = 0; frame_end = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    // test 1: reset, press at cycle 10, hold
    do_reset();
    repeat (10) step(0, 0, 0, 16'h0);
    repeat (50) step(1, 0, 0, 16'h0);
    chk("held_state", 16'(game_state), 16'h1);
    step(0, 0, 0, 16'h0);
    // test 2: 8 frames at TICK_DIV=4
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 16'h0);
      step(0, 0, 0, 16'h0);
    end
    // test 5 + 3: prescaler at 3, collision with frame_end, score 0x0123
    repeat (3) step(0, 0, 1, 16'h0);
    step(0, 1, 1, 16'h0123);
    chk("col_no_tick", 16'(score_tick), 16'h0);
    step(0, 0, 0, 16'h0123);
    step(0, 0, 0, 16'h0123);
    chk("hs_0123", high_score, 16'h0123);
    chk("nh_set", 16'(new_high), 16'h1);
    // test 4: dwell gating
    step(0, 0, 1, 16'h0);
    step(1, 0, 0, 16'h0);
    chk("early_ignored", 16'(game_state), 16'h2);
    step(0, 0, 1, 16'h0);
    step(1, 0, 0, 16'h0);
    chk("restart", 16'(game_start), 16'h1);
    step(0, 0, 1, 16'h0);
    step(0, 1, 0, 16'h0050);
    step(0, 0, 0, 16'h0050);
    step(0, 0, 0, 16'h0050);
    chk("hs_kept", high_score, 16'h0123);
    repeat (2) step(0, 0, 1, 16'h0);
    step(1, 0, 0, 16'h0);
    step(0, 1, 0, 16'h0123);
    step(0, 0, 0, 16'h0123);
    step(0, 0, 0, 16'h0123);
    chk("equal_no_nh", 16'(new_high), 16'h0);
    // test 6: game to 0x0456 then reset mid-run
    repeat (2) step(0, 0, 1, 16'h0);
    step(1, 0, 0, 16'h0);
    step(0, 1, 0, 16'h0456);
    repeat (2) step(0, 0, 0, 16'h0456);
    chk("hs_0456", high_score, 16'h0456);
    repeat (2) step(0, 0, 1, 16'h0);
    step(1, 0, 0, 16'h0);
    step(0, 0, 1, 16'h0);
    start_btn = 0; collision = 1; frame_end = 1;
    #2;
    do_reset();
    chk("rst_hs", high_score, 16'h0);
    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      bit b, c, f;
      b = ($urandom_range(0, 5) == 0) ? ~m_prev : m_prev;
      c = ($urandom_range(0, 29) == 0);
      f = ($urandom_range(0, 3) == 0);
      step(b, c, f, 16'($urandom));
      if (i == 1500) begin
        #2;
        do_reset();
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
